// File: rtl/sram_line_port_arbiter.sv
// Two-requester arbiter in front of a single-port line SRAM.
// Clears the whole RAM after reset, then grants round-robin and tracks read returns.
module sram_line_port_arbiter #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 7,
    parameter int READ_LATENCY  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_0,
    input  logic                     i_req_1,
    input  logic                     i_we_0,
    input  logic                     i_we_1,
    input  logic [ADDRESS_WIDTH-1:0] i_addr_0,
    input  logic [ADDRESS_WIDTH-1:0] i_addr_1,
    input  logic [DATA_WIDTH-1:0]    i_wdata_0,
    input  logic [DATA_WIDTH-1:0]    i_wdata_1,
    output logic                     o_gnt_0,
    output logic                     o_gnt_1,
    output logic                     o_rvalid_0,
    output logic                     o_rvalid_1,
    output logic [DATA_WIDTH-1:0]    o_rdata,
    output logic [ADDRESS_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0]    o_mem_write_data,
    output logic                     o_mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    i_mem_read_data,
    output logic                     o_init_done
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_ARB  = 1'b1;

    localparam logic [ADDRESS_WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [ADDRESS_WIDTH-1:0] CNT_LAST = '1;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("READ_LATENCY must be in 1..4");
        end
    endgenerate

    logic                     state;
    logic [ADDRESS_WIDTH-1:0] clr_cnt;
    logic                     init_done_q;
    logic                     ptr;
    logic                     gnt_0;
    logic                     gnt_1;
    logic                     rd_issue;
    logic [READ_LATENCY-1:0]  pipe_v;
    logic [READ_LATENCY-1:0]  pipe_id;

    // Pointer names the requester that wins the next tie.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (state == ST_ARB) begin
            case ({i_req_1, i_req_0})
                2'b01:   gnt_0 = 1'b1;
                2'b10:   gnt_1 = 1'b1;
                2'b11: begin
                    gnt_0 = ~ptr;
                    gnt_1 = ptr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_mem_address      = '0;
        o_mem_write_data   = '0;
        o_mem_write_enable = 1'b0;
        unique case (1'b1)
            (state == ST_INIT): begin
                o_mem_address      = clr_cnt;
                o_mem_write_enable = 1'b1;
            end
            gnt_0: begin
                o_mem_address      = i_addr_0;
                o_mem_write_data   = i_wdata_0;
                o_mem_write_enable = i_we_0;
            end
            gnt_1: begin
                o_mem_address      = i_addr_1;
                o_mem_write_data   = i_wdata_1;
                o_mem_write_enable = i_we_1;
            end
            default: ;
        endcase
    end

    assign rd_issue = (gnt_0 & ~i_we_0) | (gnt_1 & ~i_we_1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_INIT;
            clr_cnt     <= '0;
            init_done_q <= 1'b0;
        end else if (state == ST_INIT) begin
            clr_cnt <= clr_cnt + CNT_ONE;
            if (clr_cnt == CNT_LAST) begin
                state       <= ST_ARB;
                init_done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= 1'b0;
        end else if (gnt_0) begin
            ptr <= 1'b1;
        end else if (gnt_1) begin
            ptr <= 1'b0;
        end
    end

    // Stage N-1 lines up with the RAM data for a read granted N cycles ago.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v[0]  <= rd_issue;
            pipe_id[0] <= gnt_1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    assign o_gnt_0     = gnt_0;
    assign o_gnt_1     = gnt_1;
    assign o_rvalid_0  = pipe_v[READ_LATENCY-1] & ~pipe_id[READ_LATENCY-1];
    assign o_rvalid_1  = pipe_v[READ_LATENCY-1] & pipe_id[READ_LATENCY-1];
    assign o_rdata     = i_mem_read_data;
    assign o_init_done = init_done_q;

endmodule

// File: doc/sram_line_port_arbiter.md
SRAM_LINE_PORT_ARBITER -- requirements
Module: sram_line_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: line width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 7: line address width; depth = 2^ADDRESS_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 2: cycles from address presented to RAM read data valid; legal range 1..4.
REQ-004 SHALL have ports, in order:
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_req_0 / i_req_1  in  1  access request, requester 0/1
- i_we_0 / i_we_1  in  1  1 = write, 0 = read
- i_addr_0 / i_addr_1  in  ADDRESS_WIDTH  line address
- i_wdata_0 / i_wdata_1  in  DATA_WIDTH  write line
- o_gnt_0 / o_gnt_1  out  1  request accepted this cycle
- o_rvalid_0 / o_rvalid_1  out  1  read data valid for that requester
- o_rdata  out  DATA_WIDTH  read line, qualified by o_rvalid_*
- o_mem_address  out  ADDRESS_WIDTH  to RAM port address
- o_mem_write_data  out  DATA_WIDTH  to RAM port write data
- o_mem_write_enable  out  1  to RAM port write enable
- i_mem_read_data  in  DATA_WIDTH  from RAM port read data
- o_init_done  out  1  memory clear complete

Function
REQ-005 SHALL implement states INIT and ARB; reset enters INIT.
REQ-006 INIT: SHALL write zero to every line, address 0 up to 2^ADDRESS_WIDTH-1, one line per cycle; o_mem_write_enable=1, o_mem_write_data=0, o_mem_address=clear counter.
REQ-007 INIT: o_gnt_* SHALL be 0 regardless of requests; requests are not lost, merely held by requesters.
REQ-008 INIT SHALL last exactly 2^ADDRESS_WIDTH cycles; on the cycle the last line is written, the next state is ARB and o_init_done registers to 1 the following cycle.
REQ-009 ARB: o_gnt_* SHALL be combinational from i_req_* and the priority pointer; at most one grant per cycle.
REQ-010 ARB: only one request -> grant it; both -> grant the requester indicated by the priority pointer; none -> no grant, o_mem_write_enable=0.
REQ-011 Priority pointer SHALL reset to 0 and, after every grant, register to the non-granted requester (round-robin); no grant -> pointer unchanged.
REQ-012 In a grant cycle o_mem_address, o_mem_write_data, o_mem_write_enable SHALL combinationally reflect the granted requester's i_addr, i_wdata, i_we.
REQ-013 With no grant, o_mem_address and o_mem_write_data SHALL hold their last value or 0 (don't-care), but o_mem_write_enable SHALL be 0.
REQ-014 Granted read (we=0) SHALL produce o_rvalid_<n>=1 for exactly one cycle, READ_LATENCY cycles after the grant cycle, with o_rdata=i_mem_read_data in that cycle.
REQ-015 Read tracking SHALL be a READ_LATENCY-deep shift pipeline of {valid, requester id}; back-to-back reads in consecutive cycles SHALL each return in order, one per cycle, with no bubbles.
REQ-016 Granted writes SHALL produce no o_rvalid.
REQ-017 o_rvalid_0 and o_rvalid_1 SHALL never be 1 in the same cycle.
REQ-018 Read and write to the same address in consecutive grants: the read result is defined by the RAM's read-during-write behaviour; the arbiter SHALL not reorder or stall.

Reset
REQ-019 On i_rst_n low, asynchronously: state=INIT, clear counter=0, pointer=0, read pipeline cleared, o_init_done=0, o_rvalid_*=0, o_gnt_*=0.
REQ-020 Reset asserted mid-INIT or mid-ARB SHALL abort all in-flight reads (no o_rvalid after release) and restart the full clear from address 0.
REQ-021 Outputs SHALL leave reset state only on a rising i_clk edge after i_rst_n deasserts.

Verification
REQ-022 Init: ADDRESS_WIDTH=7, release reset, hold i_req_0=1 -> 128 consecutive zero writes to addresses 0..127, o_gnt_0=0 throughout, o_init_done=1 on cycle 129, o_gnt_0=1 then.
REQ-023 Contention: both requesting continuously after init -> grants alternate 0,1,0,1...; neither starves.
REQ-024 Read latency: requester 1 writes 0xA5..A5 to address 5, then reads address 5 -> o_rvalid_1=1 exactly 2 cycles after the read grant, o_rdata=0xA5..A5, o_rvalid_0=0.
REQ-025 Back-to-back reads: requester 0 read addr 3, requester 1 read addr 4 on consecutive cycles -> o_rvalid_0 then o_rvalid_1 on consecutive cycles with matching data.
REQ-026 Reset mid-operation: assert i_rst_n=0 one cycle after a read grant -> no o_rvalid appears; after release, clear restarts at address 0 and o_init_done=0 until complete.
